// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state enum, reset defaults and config legality check for clk_div_ctrl
// Honours CLK_DIV_CTRL_AUTO_DUTY_EN: when defined, only the divisor is validated.
package clk_div_pkg;

    localparam int CLK_DIV_WIDTH        = 8;
    localparam int CLK_DIV_DEFAULT_DIV  = 4;
    localparam int CLK_DIV_DEFAULT_HIGH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic cfg_legal(input logic [31:0] div, input logic [31:0] high);
`ifdef CLK_DIV_CTRL_AUTO_DUTY_EN
        return (div >= 32'd2) && (high < div);
`else
        return (div >= 32'd2) && (high != 32'd0) && (high < div);
`endif
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - period counter with registered clockout, period_tick and a wrap strobe
// A zero run forces the idle waveform; the first running edge always starts a fresh period.
module clk_div_core #(
    parameter int WIDTH = 8
) (
    input  logic             clockin,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] div_act,
    input  logic [WIDTH-1:0] high_act,
    output logic [WIDTH-1:0] count,
    output logic             clockout,
    output logic             period_tick,
    output logic             wrap
);

    logic             running;
    logic [WIDTH-1:0] count_next;

    assign wrap       = running && (count == div_act - 1'b1);
    assign count_next = (!running || wrap) ? '0 : count + 1'b1;

    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            running     <= 1'b0;
            count       <= '0;
            clockout    <= 1'b0;
            period_tick <= 1'b0;
        end else if (run) begin
            running     <= 1'b1;
            count       <= count_next;
            clockout    <= (count_next < high_act);
            period_tick <= (count_next == '0);
        end else begin
            running     <= 1'b0;
            count       <= '0;
            clockout    <= 1'b0;
            period_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run/drain FSM, config handshake and active/pending divisor registers
// Optional CLK_DIV_CTRL_AUTO_DUTY_EN derives the high time as div>>1 and ignores cfg_high.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int WIDTH        = CLK_DIV_WIDTH,
    parameter int DEFAULT_DIV  = CLK_DIV_DEFAULT_DIV,
    parameter int DEFAULT_HIGH = CLK_DIV_DEFAULT_HIGH
) (
    input  logic             clockin,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             cfg_err,
    output logic [WIDTH-1:0] count,
    output logic             clockout,
    output logic             period_tick,
    output logic             busy
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);
`ifdef CLK_DIV_CTRL_AUTO_DUTY_EN
    localparam logic [WIDTH-1:0] RESET_HIGH = WIDTH'(DEFAULT_DIV >> 1);
`else
    localparam logic [WIDTH-1:0] RESET_HIGH = WIDTH'(DEFAULT_HIGH);
`endif

    state_t           state, state_next;
    logic [WIDTH-1:0] div_act, high_act, pend_div, pend_high, new_high;
    logic             pending, xfer, legal, wrap, run;

`ifdef CLK_DIV_CTRL_AUTO_DUTY_EN
    assign new_high = cfg_div >> 1;
`else
    assign new_high = cfg_high;
`endif

    assign legal     = cfg_legal(32'(cfg_div), 32'(new_high));
    assign cfg_ready = !pending;
    assign xfer      = cfg_valid && cfg_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (!enable) state_next = DRAIN;
            DRAIN:   if (enable) state_next = RUN;
                     else if (wrap) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign run = (state_next != IDLE);

    // A new setting lands on a wrap edge (or in IDLE) so every period is whole.
    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
            pending   <= 1'b0;
            div_act   <= RESET_DIV;
            high_act  <= RESET_HIGH;
            pend_div  <= '0;
            pend_high <= '0;
        end else begin
            state   <= state_next;
            busy    <= run;
            cfg_err <= xfer && !legal;
            if (xfer && legal) begin
                if (state == IDLE || wrap) begin
                    div_act  <= cfg_div;
                    high_act <= new_high;
                end else begin
                    pend_div  <= cfg_div;
                    pend_high <= new_high;
                    pending   <= 1'b1;
                end
            end else if (pending && wrap) begin
                div_act  <= pend_div;
                high_act <= pend_high;
                pending  <= 1'b0;
            end
        end
    end

    clk_div_core #(.WIDTH(WIDTH)) u_core (
        .clockin     (clockin),
        .reset       (reset),
        .run         (run),
        .div_act     (div_act),
        .high_act    (high_act),
        .count       (count),
        .clockout    (clockout),
        .period_tick (period_tick),
        .wrap        (wrap)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed plus randomized bench for clk_div_ctrl against a period-level model
module tb_clk_div_ctrl;

    localparam int W = 8;
`ifdef CLK_DIV_CTRL_AUTO_DUTY_EN
    localparam int          REJ_D   = 1;
    localparam int          REJ_H   = 0;
    localparam logic [7:0]  PAT_6   = 8'b0011_1000;
`else
    localparam int          REJ_D   = 5;
    localparam int          REJ_H   = 5;
    localparam logic [7:0]  PAT_6   = 8'b0010_0000;
`endif

    logic         clockin = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_div = '0;
    logic [W-1:0] cfg_high = '0;
    logic         cfg_ready, cfg_err, clockout, period_tick, busy;
    logic [W-1:0] count;

    int checks = 0;
    int failures = 0;
    // model: mode 0 idle / 1 run / 2 drain, position within period, period length/high, pending config
    int m_mode, m_pos, m_n, m_h, p_v, p_n, p_h, m_err;
    logic [7:0] pat;
    int k;

    clk_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(4), .DEFAULT_HIGH(2)) dut (
        .clockin     (clockin),
        .reset       (reset),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_div     (cfg_div),
        .cfg_high    (cfg_high),
        .cfg_err     (cfg_err),
        .count       (count),
        .clockout    (clockout),
        .period_tick (period_tick),
        .busy        (busy)
    );

    always #5 clockin = ~clockin;

    function automatic bit ok_cfg(input int d, input int h);
`ifdef CLK_DIV_CTRL_AUTO_DUTY_EN
        return d >= 2;
`else
        return (d >= 2) && (h >= 1) && (h < d);
`endif
    endfunction

    function automatic int eff_high(input int d, input int h);
`ifdef CLK_DIV_CTRL_AUTO_DUTY_EN
        return d / 2;
`else
        return h;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_n = 4; m_h = 2; p_v = 0; p_n = 0; p_h = 0; m_err = 0;
    endtask

    task automatic check_all(input string ph);
        chk({ph, "_count"},  32'(count),       32'(m_pos));
        chk({ph, "_clkout"}, 32'(clockout),    32'(m_mode != 0 && m_pos < m_h));
        chk({ph, "_tick"},   32'(period_tick), 32'(m_mode != 0 && m_pos == 0));
        chk({ph, "_busy"},   32'(busy),        32'(m_mode != 0));
        chk({ph, "_ready"},  32'(cfg_ready),   32'(p_v == 0));
        chk({ph, "_err"},    32'(cfg_err),     32'(m_err));
    endtask

    task automatic cyc(input bit en, input bit cv, input int d, input int h);
        bit last, xfer, ok;
        int nmode;
        enable = en; cfg_valid = cv; cfg_div = W'(d); cfg_high = W'(h);
        last = (m_mode != 0) && (m_pos == m_n - 1);
        xfer = cv && (p_v == 0);
        ok = ok_cfg(d, h);
        m_err = int'(xfer && !ok);
        if (xfer && ok) begin
            if (m_mode == 0 || last) begin
                m_n = d; m_h = eff_high(d, h);
            end else begin
                p_v = 1; p_n = d; p_h = eff_high(d, h);
            end
        end else if (p_v != 0 && last) begin
            m_n = p_n; m_h = p_h; p_v = 0;
        end
        case (m_mode)
            0:       nmode = en ? 1 : 0;
            1:       nmode = en ? 1 : 2;
            default: nmode = en ? 1 : (last ? 0 : 2);
        endcase
        if (nmode == 0 || m_mode == 0 || last) m_pos = 0;
        else m_pos++;
        m_mode = nmode;
        @(posedge clockin);
        #1;
        check_all("cyc");
        cfg_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        reset = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // defaults: 1,1,0,0 repeating
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 0);
            pat = {pat[6:0], clockout};
        end
        chk("pattern_default", 32'(pat), 32'(8'b1100_1100));

        // config mid-period is held until the wrap
        for (k = 0; k < 8 && m_pos != 1; k++) cyc(1, 0, 0, 0);
        chk("reach_pos1", 32'(count), 32'd1);
        cyc(1, 1, 6, 1);
        chk("ready_drop", 32'(cfg_ready), 32'd0);
        cyc(1, 0, 0, 0);
        chk("old_period_pos3", 32'(count), 32'd3);
        cyc(1, 0, 0, 0);
        chk("ready_back", 32'(cfg_ready), 32'd1);
        pat = 8'(clockout);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0);
            pat = {pat[6:0], clockout};
        end
        chk("pattern_div6", 32'(pat), 32'(PAT_6));

        // illegal config: one-cycle error pulse, settings unchanged
        cyc(1, 1, REJ_D, REJ_H);
        chk("err_pulse", 32'(cfg_err), 32'd1);
        cyc(1, 0, 0, 0);
        chk("err_clear", 32'(cfg_err), 32'd0);
        cyc(1, 1, 4, 2);
        for (k = 0; k < 20 && !(m_n == 4 && m_pos == 1 && p_v == 0); k++) cyc(1, 0, 0, 0);
        chk("restore_pos1", 32'(count), 32'd1);

        // drain completes the period then idles
        for (k = 0; k < 10 && m_mode != 0; k++) cyc(0, 0, 0, 0);
        chk("drain_len", 32'(k), 32'd3);
        chk("drain_idle_busy", 32'(busy), 32'd0);
        chk("drain_idle_clk", 32'(clockout), 32'd0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("reenable_tick", 32'(period_tick), 32'd1);

        // config on the wrap edge applies immediately
        for (k = 0; k < 8 && m_pos != 3; k++) cyc(1, 0, 0, 0);
        chk("reach_pos3", 32'(count), 32'd3);
        cyc(1, 1, 3, 1);
        chk("wrap_apply_count", 32'(count), 32'd0);
        pat = 8'(clockout);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0, 0);
            pat = {pat[6:0], clockout};
        end
        chk("pattern_div3", 32'(pat), 32'(8'b0000_0100));
        cyc(1, 0, 0, 0);
        chk("wrap3_tick", 32'(period_tick), 32'd1);

        // asynchronous reset with a pending config
        cyc(1, 0, 0, 0);
        cyc(1, 1, 7, 3);
        chk("pending_before_reset", 32'(cfg_ready), 32'd0);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        #1 reset = 1'b0;
`ifdef CLK_DIV_CTRL_AUTO_DUTY_EN
        cyc(0, 1, 7, 0);
        pat = '0;
        for (int i = 0; i < 7; i++) begin
            cyc(1, 0, 0, 0);
            pat = {pat[6:0], clockout};
        end
        chk("pattern_auto7", 32'(pat), 32'(8'b0111_0000));
`else
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 0);
            pat = {pat[6:0], clockout};
        end
        chk("pattern_after_reset", 32'(pat), 32'(8'b1100_1100));
`endif

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 8), ($urandom_range(0, 4) == 0),
                int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
